// File: rtl/or_gate_unit.sv
// rtl/or_gate_unit.sv - bitwise OR gate with registered, sticky and hit-count observability (optional NOR outputs under OR_GATE_NOR_OUT_EN)
module or_gate_unit #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  input  logic             sticky_clr,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] c_q,
  output logic             out_valid,
`ifdef OR_GATE_NOR_OUT_EN
  output logic [WIDTH-1:0] c_n,
  output logic [WIDTH-1:0] c_n_q,
`endif
  output logic [WIDTH-1:0] sticky,
  output logic [CNT_W-1:0] hit_count
);

  logic hit;

  // combinational OR result, independent of clock, reset and valid
  always_comb begin
    c   = a | b;
    hit = |(a | b);
  end

  // registered result: capture on valid, hold otherwise; out_valid tracks in_valid one cycle later
  always_ff @(posedge clk) begin
    if (rst) begin
      c_q       <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        c_q <= a | b;
      end
    end
  end

  // sticky accumulator: clear wins over a concurrent valid input
  always_ff @(posedge clk) begin
    if (rst || sticky_clr) begin
      sticky <= '0;
    end else if (in_valid) begin
      sticky <= sticky | a | b;
    end
  end

  // saturating count of valid cycles with a nonzero result; clear wins over a concurrent hit
  always_ff @(posedge clk) begin
    if (rst || sticky_clr) begin
      hit_count <= '0;
    end else if (in_valid && hit && !(&hit_count)) begin
      hit_count <= hit_count + 1'b1;
    end
  end

`ifdef OR_GATE_NOR_OUT_EN
  // combinational NOR of the operands
  always_comb begin
    c_n = ~(a | b);
  end

  // registered NOR, same capture/hold rules as c_q; resets to the NOR of c_q's reset value
  always_ff @(posedge clk) begin
    if (rst) begin
      c_n_q <= '1;
    end else if (in_valid) begin
      c_n_q <= ~(a | b);
    end
  end
`endif

endmodule

// File: tb/tb_or_gate_unit.sv
// tb/tb_or_gate_unit.sv - self-checking bench for or_gate_unit with directed steps and randomized traffic
module tb_or_gate_unit;

  localparam int WIDTH = 2;
  localparam int CNT_W = 2;
  localparam int MASK  = (1 << WIDTH) - 1;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             in_valid;
  logic             sticky_clr;
  logic [WIDTH-1:0] c;
  logic [WIDTH-1:0] c_q;
  logic             out_valid;
  logic [WIDTH-1:0] sticky;
  logic [CNT_W-1:0] hit_count;
`ifdef OR_GATE_NOR_OUT_EN
  logic [WIDTH-1:0] c_n;
  logic [WIDTH-1:0] c_n_q;
`endif

  int n_vec  = 0;
  int n_miss = 0;

  // reference model state, plain integers
  int m_cq, m_ov, m_st, m_hc, m_cnq;

  or_gate_unit #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .a          (a),
    .b          (b),
    .in_valid   (in_valid),
    .sticky_clr (sticky_clr),
    .c          (c),
    .c_q        (c_q),
    .out_valid  (out_valid),
`ifdef OR_GATE_NOR_OUT_EN
    .c_n        (c_n),
    .c_n_q      (c_n_q),
`endif
    .sticky     (sticky),
    .hit_count  (hit_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int ref_or(input int x, input int y);
    return (x | y) & MASK;
  endfunction

  // what one rising edge does to the observable state
  task automatic model_edge();
    int r;
    r = ref_or(int'(a), int'(b));
    if (rst) begin
      m_cq = 0; m_ov = 0; m_st = 0; m_hc = 0; m_cnq = MASK;
    end else begin
      m_ov = int'(in_valid);
      if (in_valid) begin
        m_cq  = r;
        m_cnq = (~r) & MASK;
      end
      if (sticky_clr) begin
        m_st = 0;
        m_hc = 0;
      end else if (in_valid) begin
        m_st = m_st | r;
        if (r != 0) m_hc = (m_hc + 1 > CMAX) ? CMAX : m_hc + 1;
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".c"},         32'(c),         32'(ref_or(int'(a), int'(b))));
    chk({tag, ".c_q"},       32'(c_q),       32'(m_cq));
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(m_ov));
    chk({tag, ".sticky"},    32'(sticky),    32'(m_st));
    chk({tag, ".hit_count"}, 32'(hit_count), 32'(m_hc));
`ifdef OR_GATE_NOR_OUT_EN
    chk({tag, ".c_n"},       32'(c_n),       32'((~ref_or(int'(a), int'(b))) & MASK));
    chk({tag, ".c_n_q"},     32'(c_n_q),     32'(m_cnq));
`endif
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic drive(input logic r, input logic v, input logic cl, input int av, input int bv);
    rst        = r;
    in_valid   = v;
    sticky_clr = cl;
    a          = WIDTH'(av);
    b          = WIDTH'(bv);
  endtask

  initial begin
    m_cq = 0; m_ov = 0; m_st = 0; m_hc = 0; m_cnq = MASK;
    drive(1'b1, 1'b0, 1'b0, 0, 0);

    // reset state
    step("reset");
    chk("reset.c_q", 32'(c_q), 32'd0);
    chk("reset.out_valid", 32'(out_valid), 32'd0);
    chk("reset.sticky", 32'(sticky), 32'd0);
    chk("reset.hit_count", 32'(hit_count), 32'd0);
`ifdef OR_GATE_NOR_OUT_EN
    chk("reset.c_n_q", 32'(c_n_q), 32'(MASK));
`endif

    // exhaustive single-bit truth table, no clock edge needed
    drive(1'b0, 1'b0, 1'b0, 0, 0); #1; chk("tt00", 32'(c[0]), 32'd0);
`ifdef OR_GATE_NOR_OUT_EN
    chk("tt00.c_n", 32'(c_n[0]), 32'd1);
`endif
    drive(1'b0, 1'b0, 1'b0, 0, 1); #1; chk("tt01", 32'(c[0]), 32'd1);
    drive(1'b0, 1'b0, 1'b0, 1, 0); #1; chk("tt10", 32'(c[0]), 32'd1);
    drive(1'b0, 1'b0, 1'b0, 1, 1); #1; chk("tt11", 32'(c[0]), 32'd1);
`ifdef OR_GATE_NOR_OUT_EN
    chk("tt11.c_n", 32'(c_n[0]), 32'd0);
`endif

    // one-cycle latency, then hold when invalid
    drive(1'b0, 1'b1, 1'b0, 1, 0);
    step("lat1");
    chk("lat1.c_q", 32'(c_q), 32'd1);
    chk("lat1.out_valid", 32'(out_valid), 32'd1);
    drive(1'b0, 1'b0, 1'b0, 0, 0);
    step("lat2");
    chk("lat2.c_q", 32'(c_q), 32'd1);
    chk("lat2.out_valid", 32'(out_valid), 32'd0);

    // sticky accumulate then clear-with-valid
    drive(1'b0, 1'b0, 1'b1, 0, 0); step("clr0");
    drive(1'b0, 1'b1, 1'b0, 1, 0); step("st1");
    drive(1'b0, 1'b1, 1'b0, 2, 0); step("st2");
    chk("st2.sticky", 32'(sticky), 32'd3);
    drive(1'b0, 1'b1, 1'b1, 1, 0); step("stclr");
    chk("stclr.sticky", 32'(sticky), 32'd0);
    chk("stclr.hit_count", 32'(hit_count), 32'd0);

    // saturation: 1,2,3,3,3
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b1, 1'b0, 1, 0);
      step("sat");
      chk($sformatf("sat%0d.hit_count", i), 32'(hit_count), 32'((i + 1 > 3) ? 3 : i + 1));
    end
    drive(1'b0, 1'b0, 1'b1, 0, 0); step("clr1");
    drive(1'b0, 1'b1, 1'b0, 0, 0); step("zero");
    chk("zero.hit_count", 32'(hit_count), 32'd0);

    // reset mid-stream discards the concurrent input
    drive(1'b0, 1'b1, 1'b0, 1, 0); step("pre1");
    drive(1'b0, 1'b1, 1'b0, 1, 0); step("pre2");
    chk("pre2.hit_count", 32'(hit_count), 32'd2);
    chk("pre2.sticky", 32'(sticky), 32'd1);
    drive(1'b1, 1'b1, 1'b0, 1, 0); step("midrst");
    chk("midrst.c_q", 32'(c_q), 32'd0);
    chk("midrst.out_valid", 32'(out_valid), 32'd0);
    chk("midrst.sticky", 32'(sticky), 32'd0);
    chk("midrst.hit_count", 32'(hit_count), 32'd0);
    chk("midrst.c", 32'(c), 32'd1);

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 31) == 0), $urandom_range(0, 3) != 0,
            ($urandom_range(0, 15) == 0), int'($urandom_range(0, MASK)),
            int'($urandom_range(0, MASK)));
      if ($urandom_range(0, 3) == 0) begin
        a = '0;
        b = '0;
      end
      step("rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
